// File: rtl/nf_key_reg_sel_if.sv
// Key/address bundle between the board buttons and the debug register selector.
// The master side drives the raw keys; the slave side returns the selected address and status.
interface nf_key_reg_sel_if;
  logic [3:0] key;
  logic [4:0] reg_addr;
  logic       auto_scan;
  logic [3:0] key_db;

  modport master (output key, input reg_addr, input auto_scan, input key_db);
  modport slave  (input key, output reg_addr, output auto_scan, output key_db);
endinterface

// File: rtl/nf_key_reg_sel.sv
// Debounced push-button control of the nanoFOX debug scan register address:
// increment, decrement, clear and a timed auto-scan over 0..ADDR_MAX.
module nf_key_reg_sel #(
  parameter int DB_CYCLES   = 500000,
  parameter int SCAN_CYCLES = 50000000,
  parameter int ADDR_MAX    = 31
) (
  input  logic               clk,
  input  logic               resetn,
  nf_key_reg_sel_if.slave    bus
);

  localparam int              DBW     = $clog2(DB_CYCLES);
  localparam int              SCW     = $clog2(SCAN_CYCLES);
  localparam logic [DBW-1:0]  DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [SCW-1:0]  SC_LAST = SCW'(SCAN_CYCLES - 1);
  localparam logic [4:0]      AMAX    = 5'(ADDR_MAX);

  logic [3:0]     r_sync1;
  logic [3:0]     r_sync2;
  logic [3:0]     r_key_db;
  logic [3:0]     r_key_db_d;
  logic [3:0]     r_press;
  logic [DBW-1:0] r_db_cnt [4];
  logic [SCW-1:0] r_scan_cnt;
  logic           r_auto;
  logic [4:0]     r_addr;

  logic           w_manual;
  logic           w_scan_wrap;
  logic           w_auto_step;
  logic [4:0]     w_addr_nxt;

  function automatic logic [4:0] f_inc(input logic [4:0] a);
    return (a == AMAX) ? 5'd0 : a + 5'd1;
  endfunction

  function automatic logic [4:0] f_dec(input logic [4:0] a);
    return (a == 5'd0) ? AMAX : a - 5'd1;
  endfunction

  // Synchronizers idle high so a released (active-low) key never looks pressed out of reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1    <= 4'hF;
      r_sync2    <= 4'hF;
      r_key_db   <= 4'hF;
      r_key_db_d <= 4'hF;
      r_press    <= 4'h0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1    <= bus.key;
      r_sync2    <= r_sync1;
      r_key_db_d <= r_key_db;
      r_press    <= r_key_db_d & ~r_key_db;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_key_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_key_db[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_manual    = |r_press[2:0];
  assign w_scan_wrap = (r_scan_cnt == SC_LAST);
  // A manual action on the same edge as a scheduled auto step wins; only one change per edge
  assign w_auto_step = r_auto && w_scan_wrap && !w_manual;

  always_comb begin
    w_addr_nxt = r_addr;
    if (r_press[2])                   w_addr_nxt = 5'd0;
    else if (r_press[0] && r_press[1]) w_addr_nxt = r_addr;
    else if (r_press[0])               w_addr_nxt = f_inc(r_addr);
    else if (r_press[1])               w_addr_nxt = f_dec(r_addr);
    else if (w_auto_step)              w_addr_nxt = f_inc(r_addr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr     <= 5'd0;
      r_auto     <= 1'b0;
      r_scan_cnt <= '0;
    end else begin
      r_addr <= w_addr_nxt;
      r_auto <= r_auto ^ r_press[3];
      // Restarting on toggle or manual action keeps the next auto step a full interval away
      if (!r_auto || r_press[3] || w_manual || w_scan_wrap) r_scan_cnt <= '0;
      else                                                 r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign bus.reg_addr  = r_addr;
  assign bus.auto_scan = r_auto;
  assign bus.key_db    = r_key_db;

endmodule

// File: tb/tb_nf_key_reg_sel.sv
// Bench for nf_key_reg_sel: directed scenarios plus random key activity, checked every
// cycle against a sample-window / timestamp model for ADDR_MAX=31 and ADDR_MAX=9 instances.
module tb_nf_key_reg_sel;
  localparam int DB   = 4;
  localparam int SCAN = 8;

  logic clk;
  logic resetn;
  int   n_chk;
  int   n_err;

  nf_key_reg_sel_if u_if ();
  nf_key_reg_sel_if u_if9 ();
  assign u_if9.key = u_if.key;

  nf_key_reg_sel #(.DB_CYCLES(DB), .SCAN_CYCLES(SCAN), .ADDR_MAX(31)) dut (
    .clk(clk), .resetn(resetn), .bus(u_if));
  nf_key_reg_sel #(.DB_CYCLES(DB), .SCAN_CYCLES(SCAN), .ADDR_MAX(9)) dut9 (
    .clk(clk), .resetn(resetn), .bus(u_if9));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a key level flips once the last DB synchronized samples all disagree with it;
  // a fall is acted on two edges later; auto steps happen at scheduled edge numbers.
  logic [3:0] h [0:DB];
  logic [3:0] m_db, m_ndb, pend0, pend1, act;
  logic       m_auto;
  logic [4:0] m_addr [2];
  int         amax [2];
  int         m_cyc, m_nxt;
  bit         all_diff, step;

  initial begin
    amax[0] = 31;
    amax[1] = 9;
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int j = 0; j <= DB; j++) h[j] = 4'hF;
      m_db = 4'hF; pend0 = 4'h0; pend1 = 4'h0; m_auto = 1'b0;
      m_addr[0] = 5'd0; m_addr[1] = 5'd0; m_cyc = 0; m_nxt = 0;
    end else begin
      m_cyc++;
      act   = pend1;
      m_ndb = m_db;
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DB; j++) if (h[j][i] == m_db[i]) all_diff = 1'b0;
        if (all_diff) m_ndb[i] = ~m_db[i];
      end
      pend1 = pend0;
      pend0 = m_db & ~m_ndb;
      m_db  = m_ndb;
      for (int j = DB; j >= 1; j--) h[j] = h[j-1];
      h[0] = u_if.key;
      step = m_auto && (m_cyc == m_nxt) && (act[2:0] == 3'b000);
      for (int d = 0; d < 2; d++) begin
        if (act[2])                m_addr[d] = 5'd0;
        else if (act[0] && act[1]) m_addr[d] = m_addr[d];
        else if (act[0] || step)   m_addr[d] = (int'(m_addr[d]) == amax[d]) ? 5'd0 : m_addr[d] + 5'd1;
        else if (act[1])           m_addr[d] = (m_addr[d] == 5'd0) ? 5'(amax[d]) : m_addr[d] - 5'd1;
      end
      if (act[2:0] != 3'b000 || step) m_nxt = m_cyc + SCAN;
      if (act[3]) begin
        m_auto = ~m_auto;
        if (m_auto) m_nxt = m_cyc + SCAN;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("addr31", u_if.reg_addr, m_addr[0]);
    chk("addr9", u_if9.reg_addr, m_addr[1]);
    chk("auto31", u_if.auto_scan, m_auto);
    chk("auto9", u_if9.auto_scan, m_auto);
    chk("db31", u_if.key_db, m_db);
    chk("db9", u_if9.key_db, m_db);
  end

  task automatic press(input logic [3:0] m, input int hold, input int gap);
    @(negedge clk) u_if.key = ~m;
    repeat (hold) @(negedge clk);
    u_if.key = 4'hF;
    repeat (gap) @(negedge clk);
  endtask

  // Call just after a rising edge; polls for a bounded number of cycles.
  task automatic wait_auto(input logic v, input string nm);
    for (int k = 0; k < 40 && u_if.auto_scan !== v; k++) begin
      @(posedge clk);
      #1;
    end
    chk(nm, u_if.auto_scan, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0;
    u_if.key = 4'hF;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    chk("rst_addr", u_if.reg_addr, 0);
    chk("rst_auto", u_if.auto_scan, 0);
    chk("rst_db", u_if.key_db, 15);

    // Latency: first low sample is edge E0, address moves on E7
    @(negedge clk) u_if.key = 4'hE;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1 chk("lat_e6", u_if.reg_addr, 0);
    @(posedge clk);
    #1 chk("lat_e7", u_if.reg_addr, 1);
    repeat (13) @(negedge clk);
    u_if.key = 4'hF;
    repeat (15) @(negedge clk);
    chk("lat_hold", u_if.reg_addr, 1);

    // Bounce before a stable low: one increment only
    @(negedge clk) u_if.key = 4'hE;
    repeat (2) @(negedge clk); u_if.key = 4'hF;
    @(negedge clk);            u_if.key = 4'hE;
    repeat (2) @(negedge clk); u_if.key = 4'hF;
    @(negedge clk);            u_if.key = 4'hE;
    repeat (10) @(negedge clk); u_if.key = 4'hF;
    repeat (15) @(negedge clk);
    chk("bounce", u_if.reg_addr, 2);

    press(4'b0100, 10, 15); chk("clear", u_if.reg_addr, 0);
    press(4'b0010, 10, 15); chk("dec_wrap31", u_if.reg_addr, 31);
    chk("dec_wrap9", u_if9.reg_addr, 9);
    press(4'b0001, 10, 15); chk("inc_wrap31", u_if.reg_addr, 0);
    chk("inc_wrap9", u_if9.reg_addr, 0);
    press(4'b0001, 10, 15);
    press(4'b0011, 10, 15); chk("inc_dec", u_if.reg_addr, 1);
    repeat (4) press(4'b0001, 10, 15);
    chk("at5", u_if.reg_addr, 5);
    press(4'b0101, 10, 15); chk("clr_pri", u_if.reg_addr, 0);

    // Auto-scan: T is the edge auto_scan rises
    @(negedge clk) u_if.key = 4'h7;
    @(posedge clk); #1;
    wait_auto(1'b1, "auto_on");
    repeat (7) @(posedge clk); #1 chk("scan_t7", u_if.reg_addr, 0);
    @(posedge clk);            #1 chk("scan_t8", u_if.reg_addr, 1);
    repeat (4) @(posedge clk);
    @(negedge clk) u_if.key = 4'hE;
    repeat (4) @(posedge clk); #1 chk("scan_t16", u_if.reg_addr, 2);
    repeat (3) @(posedge clk); #1 chk("man_t19", u_if.reg_addr, 2);
    @(posedge clk);            #1 chk("man_t20", u_if.reg_addr, 3);
    repeat (7) @(posedge clk); #1 chk("scan_t27", u_if.reg_addr, 3);
    @(negedge clk) u_if.key = 4'hF;
    @(posedge clk);            #1 chk("scan_t28", u_if.reg_addr, 4);
    repeat (2) @(posedge clk);
    @(negedge clk) u_if.key = 4'h7;
    @(posedge clk); #1;
    wait_auto(1'b0, "auto_off");
    @(negedge clk) u_if.key = 4'hF;
    repeat (40) @(negedge clk);
    chk("frozen", u_if.reg_addr, 5);
    chk("frozen_auto", u_if.auto_scan, 0);

    // Asynchronous reset during auto-scan and a pending debounce
    @(negedge clk) u_if.key = 4'h7;
    @(posedge clk); #1;
    wait_auto(1'b1, "auto_on2");
    @(negedge clk) u_if.key = 4'hE;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("amid_addr", u_if.reg_addr, 0);
    chk("amid_auto", u_if.auto_scan, 0);
    chk("amid_db", u_if.key_db, 15);
    u_if.key = 4'hF;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    u_if.key = 4'hE;
    repeat (3) @(negedge clk);
    u_if.key = 4'hF;
    repeat (20) @(negedge clk);
    chk("glitch_addr", u_if.reg_addr, 0);
    chk("glitch_db", u_if.key_db, 15);

    // Random key activity, mostly released, with occasional resets
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 99) < 3) begin
        @(negedge clk) resetn = 1'b0;
        @(negedge clk) resetn = 1'b1;
      end
      @(negedge clk) u_if.key = ~(4'($urandom) & 4'($urandom));
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end
    u_if.key = 4'hF;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/nf_key_reg_sel.md
Name: nf_key_reg_sel

Overview:
- Upstream neighbour of the board-level debug path.
- Takes the four raw, bouncing, active-low push-buttons and produces the 5-bit scan register address driven into the nanoFOX core's reg_addr debug port.
- Replaces the direct key-to-address wiring, which reaches only registers 0..15, with debounced increment/decrement/clear/auto-scan control over the full register file.
- Sits between board pins and nf_top; its output feeds the register-scan path consumed by the seven-segment or VGA debug display.

Parameters:
- DB_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); must be >= 2.
- SCAN_CYCLES, 50000000, clocks between automatic address steps in auto-scan mode (1 s at 50 MHz); must be >= 2.
- ADDR_MAX, 31, highest reachable address; range 0..31.

Ports:
- clk  input  1  system clock
- resetn  input  1  reset, active-low
- key  input  4  raw buttons, active-low (0 = pressed); key[0]=inc, key[1]=dec, key[2]=clear, key[3]=auto-scan toggle
- reg_addr  output  5  selected scan register address
- auto_scan  output  1  1 = auto-scan mode active
- key_db  output  4  debounced key levels, active-low

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous, active-low. No other clock domains.
- Reset values:
  - reg_addr = 0, auto_scan = 0, key_db = 4'hF.
  - Synchronizer FFs = 1. All counters = 0.
- Synchronization: each key bit passes through a 2-FF synchronizer before any other logic.
- Debounce, independent per key:
  - Counter increments while the synchronized level differs from key_db[i].
  - Counter clears on any cycle where the levels are equal.
  - When the counter reaches DB_CYCLES-1 while still mismatched, key_db[i] takes the synchronized level on the next edge and the counter clears.
  - A glitch shorter than DB_CYCLES cycles produces no key_db change.
- Press event: a registered 1-cycle pulse press[i] when key_db[i] goes 1->0. Releases (0->1) generate nothing.
- Latency: a raw key held low continuously changes reg_addr/auto_scan exactly DB_CYCLES+3 clock edges after the first sampling edge that sees it low.
- Action priority for the edge following the press pulses:
  1. press[2] (clear): reg_addr <= 0; overrides inc and dec.
  2. press[0] and press[1] together: reg_addr unchanged.
  3. press[0] alone: reg_addr <= (reg_addr == ADDR_MAX) ? 0 : reg_addr+1.
  4. press[1] alone: reg_addr <= (reg_addr == 0) ? ADDR_MAX : reg_addr-1.
  - press[3] toggles auto_scan, independently of and in the same edge as the above.
- Auto-scan:
  - While auto_scan = 1, scan counter counts 0..SCAN_CYCLES-1.
  - At SCAN_CYCLES-1 the counter wraps to 0 and reg_addr steps with the same wrap rule as inc.
  - Scan counter is held at 0 while auto_scan = 0.
  - Scan counter clears on the edge auto_scan turns on, and on any manual press[0..2].
  - A manual action takes precedence over a coinciding auto step: only one change per edge.
- Range: reg_addr never exceeds ADDR_MAX.
- Reset mid-operation: asynchronous assertion returns all state to reset values immediately; pending debounce progress is discarded.
- Key held: a single press event only; no auto-repeat.

Test Plan (bench uses DB_CYCLES=4, SCAN_CYCLES=8, ADDR_MAX=31):
- Reset release, keys all high for 50 cycles -> reg_addr=0, auto_scan=0, key_db=4'hF throughout.
- key[0] low for 20 cycles then high -> reg_addr becomes 1 exactly 7 edges after first low sample; stays 1. Bounce pattern low 2 / high 1 / low 2 before a stable low -> still exactly one increment.
- From reg_addr=0, press key[1] -> reg_addr=31. Then press key[0] -> reg_addr=0. With ADDR_MAX=9 and reg_addr=9, press key[0] -> 0.
- key[0] and key[1] pressed on the same cycle -> reg_addr unchanged. key[2] pressed together with key[0] at reg_addr=5 -> reg_addr=0.
- Press key[3] -> auto_scan=1; reg_addr steps 0->1->2 every 8 cycles. A key[0] press mid-interval resets spacing (next auto step 8 cycles after the manual step). Press key[3] again -> auto_scan=0, reg_addr frozen.
- Assert resetn low mid-debounce and mid-auto-scan -> outputs return to reset values within the same cycle. After release, a key held low for fewer than 4 cycles yields no change.
